// File: rtl/rggen_bit_field_access_arbiter.sv
// ----------------------------------------------------------------------------
// rggen_bit_field_access_arbiter
//
// Shares one rw bit field among REQUESTERS masters. Round-robin arbitration,
// one access in flight, fixed IDLE -> ACCESS -> RESPOND sequence (3 cycles).
// The response carries the field value seen in RESPOND, i.e. after the write
// issued in ACCESS has landed.
//
// Parameters
//   WIDTH       bit-field width
//   REQUESTERS  number of requesters (>= 2)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_req_valid         per-requester request
//   o_req_ready         per-requester accept (one-hot or zero, IDLE only)
//   i_req_write         per-requester 1=write, 0=read
//   i_req_write_data    packed, requester k at [k*WIDTH +: WIDTH]
//   i_req_write_mask    packed, same layout
//   o_rsp_valid         one-cycle response pulse to the granted requester
//   o_rsp_data          field value returned with the response (0 otherwise)
//   o_command_valid, o_select, o_write, o_write_data, o_write_mask
//                       command to the bit field, active only in ACCESS
//   i_value             current bit-field value
//   i_req_lock          owner lock for read-modify-write sequences
//                       (present only when RGGEN_ARBITER_LOCK_EN is defined)
//
// Build option
//   RGGEN_ARBITER_LOCK_EN : adds i_req_lock. An owner that holds its lock at
//   RESPOND keeps exclusive access until it drops the lock; while locked with
//   valid low the arbiter idles.
// ----------------------------------------------------------------------------
module rggen_bit_field_access_arbiter #(
    parameter int WIDTH      = 1,
    parameter int REQUESTERS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REQUESTERS-1:0]       i_req_valid,
    output logic [REQUESTERS-1:0]       o_req_ready,
    input  logic [REQUESTERS-1:0]       i_req_write,
    input  logic [REQUESTERS*WIDTH-1:0] i_req_write_data,
    input  logic [REQUESTERS*WIDTH-1:0] i_req_write_mask,
    output logic [REQUESTERS-1:0]       o_rsp_valid,
    output logic [WIDTH-1:0]            o_rsp_data,
    output logic                        o_command_valid,
    output logic                        o_select,
    output logic                        o_write,
    output logic [WIDTH-1:0]            o_write_data,
    output logic [WIDTH-1:0]            o_write_mask,
`ifdef RGGEN_ARBITER_LOCK_EN
    input  logic [REQUESTERS-1:0]       i_req_lock,
`endif
    input  logic [WIDTH-1:0]            i_value
);

    localparam int IW = $clog2(REQUESTERS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                  state;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           grant;
    logic                    wr_q;
    logic [WIDTH-1:0]        data_q;
    logic [WIDTH-1:0]        mask_q;
    logic                    cmd_q;
    logic [REQUESTERS-1:0]   rsp_q;

    logic                    win_found;
    logic [IW-1:0]           win;
    logic [IW-1:0]           ptr_next;

`ifdef RGGEN_ARBITER_LOCK_EN
    logic locked;
    // The previous owner still holds its lock: nobody else may be considered.
    logic owner_hold;
    assign owner_hold = locked && i_req_lock[grant];
`endif

    // Round-robin search starting at ptr, wrapping at REQUESTERS-1.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            int k;
            k = (int'(ptr) + i) % REQUESTERS;
            if (!win_found && i_req_valid[k]) begin
                win_found = 1'b1;
                win       = IW'(k);
            end
        end
`ifdef RGGEN_ARBITER_LOCK_EN
        if (owner_hold) begin
            win_found = i_req_valid[grant];
            win       = grant;
        end
`endif
    end

    always_comb begin
        o_req_ready = '0;
        if (state == IDLE && !rst && win_found)
            o_req_ready[win] = 1'b1;
    end

    assign ptr_next = (grant == IW'(REQUESTERS - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            grant  <= '0;
            wr_q   <= 1'b0;
            data_q <= '0;
            mask_q <= '0;
            cmd_q  <= 1'b0;
            rsp_q  <= '0;
`ifdef RGGEN_ARBITER_LOCK_EN
            locked <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef RGGEN_ARBITER_LOCK_EN
                    if (locked && !i_req_lock[grant])
                        locked <= 1'b0;
`endif
                    if (win_found) begin
                        grant  <= win;
                        wr_q   <= i_req_write[win];
                        // Reads carry zero data/mask to the field.
                        data_q <= i_req_write[win] ? i_req_write_data[int'(win)*WIDTH +: WIDTH] : '0;
                        mask_q <= i_req_write[win] ? i_req_write_mask[int'(win)*WIDTH +: WIDTH] : '0;
                        cmd_q  <= 1'b1;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    cmd_q <= 1'b0;
                    rsp_q <= {{(REQUESTERS-1){1'b0}}, 1'b1} << grant;
                    state <= RESPOND;
                end
                RESPOND: begin
                    rsp_q <= '0;
                    // Advancing ptr is harmless under lock: owner_hold
                    // overrides the search until the lock is released.
                    ptr   <= ptr_next;
`ifdef RGGEN_ARBITER_LOCK_EN
                    locked <= i_req_lock[grant];
`endif
                    state <= IDLE;
                end
                default: begin
                    cmd_q <= 1'b0;
                    rsp_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low in the reset cycle so an aborted access never
    // reaches the field or the requester.
    assign o_command_valid = cmd_q && !rst;
    assign o_select        = cmd_q && !rst;
    assign o_write         = cmd_q && wr_q && !rst;
    assign o_write_data    = (cmd_q && !rst) ? data_q : '0;
    assign o_write_mask    = (cmd_q && !rst) ? mask_q : '0;
    assign o_rsp_valid     = rst ? '0 : rsp_q;
    // i_value is sampled live so writes from ACCESS are reflected.
    assign o_rsp_data      = (|o_rsp_valid) ? i_value : '0;

endmodule
